slt_seq_cmp: RTL and testbench
==============================

SLT_SEQ_CMP -- requirements
Module: slt_seq_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin a comparison.
REQ-006 SHALL have port signed_mode, input, 1, selects two's-complement (1) or unsigned (0) compare.
REQ-007 SHALL have ports a and b, input, WIDTH, the operands.
REQ-008 SHALL have port busy, output, 1, high while a comparison is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when a result becomes valid.
REQ-010 SHALL have port lt, output, 1, high when a < b.
REQ-011 SHALL have port eq, output, 1, high when a == b.
REQ-012 SHALL have port res, output, WIDTH, set-less-than word: {WIDTH-1 zeros, lt}.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; N = WIDTH/CHUNK.
REQ-014 Transition IDLE->RUN and DONE->RUN SHALL occur on a clock edge with start=1; the start edge SHALL latch a, b and signed_mode.
REQ-015 Operands SHALL be loaded with MSB inverted when signed_mode=1, so that an unsigned compare yields the signed result.
REQ-016 RUN SHALL examine one CHUNK-bit slice per cycle, MSB slice first (index 0), shifting both operands left by CHUNK each cycle, with a down-counter from N-1.
REQ-017 When the slices differ, or the last slice (index N-1) is examined, RUN SHALL register lt/eq and go to DONE.
REQ-018 Latency SHALL be: done asserted d+2 cycles after the start edge, where d is the index of the deciding slice; an equal compare has d = N-1.
REQ-019 DONE SHALL last exactly one cycle with done=1, then go to IDLE unless start=1.
REQ-020 busy SHALL be 1 exactly in RUN; start while busy SHALL be ignored with no effect on the running compare.
REQ-021 lt, eq and res SHALL hold their value from DONE until the next DONE, and SHALL remain stable while RUN is active.
REQ-022 lt and eq SHALL never both be 1.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, with busy=0, done=0, lt=0, eq=0 and res=0, including mid-RUN; the interrupted compare SHALL be discarded with no done pulse.
REQ-024 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-025 Macro SLT_EARLY_TERM_EN defined: early exit per REQ-017 (variable latency d+2).
REQ-026 SLT_EARLY_TERM_EN undefined: RUN SHALL always take N cycles, with the first differing slice remembered; latency SHALL be fixed at N+1; results SHALL be identical to the defined case.

Structure
REQ-027 Package slt_pkg SHALL hold the FSM state enum and the default WIDTH/CHUNK constants.
REQ-028 Combinational sub-module slt_chunk_cmp SHALL produce slice-level lt/eq for CHUNK-bit inputs; it SHALL be instantiated once.

Verification (WIDTH=32, CHUNK=4, macro defined unless stated)
REQ-029 Unsigned a=5, b=7 -> lt=1, eq=0, res=0x00000001, done 9 cycles after start.
REQ-030 a=0x80000000, b=1: unsigned -> lt=0, done after 2 cycles; signed -> lt=1, res=1, done after 2 cycles.
REQ-031 a=b=0xDEADBEEF -> eq=1, lt=0, res=0, done after 9 cycles.
REQ-032 start pulsed during RUN with new operands -> ignored, first result reported; start asserted in the DONE cycle -> new compare accepted, busy next cycle.
REQ-033 rst_n low in the 3rd RUN cycle -> busy=0, res=0 immediately, no done pulse; next compare correct.
REQ-034 Macro undefined, repeat REQ-030 unsigned -> same result, done after 9 cycles.

Source files
------------

// File: rtl/slt_pkg.sv
`default_nettype none
// ============================================================
// slt_pkg : FSM state type and default sizes for slt_seq_cmp
// Rev 1.0 - initial release
// ============================================================
package slt_pkg;

  localparam int c_def_width = 32;
  localparam int c_def_chunk = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } slt_state_e;

endpackage
`default_nettype wire

// File: rtl/slt_chunk_cmp.sv
`default_nettype none
// ============================================================
// slt_chunk_cmp : unsigned less-than / equal on one CHUNK-bit slice
// Rev 1.0 - initial release
// ============================================================
module slt_chunk_cmp
  import slt_pkg::*;
#(
  parameter int CHUNK = c_def_chunk
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_lt,
  output logic             o_eq
);

  assign o_lt = (i_a < i_b);
  assign o_eq = (i_a == i_b);

endmodule
`default_nettype wire

// File: rtl/slt_seq_cmp.sv
`default_nettype none
// ============================================================
// slt_seq_cmp : sequential set-less-than, CHUNK bits per cycle, MSB first.
// SLT_EARLY_TERM_EN selects early exit on the first differing slice.
// Rev 1.0 - initial release
// ============================================================
module slt_seq_cmp
  import slt_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int CHUNK = c_def_chunk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic [WIDTH-1:0] res
);

  localparam int              c_n   = WIDTH / CHUNK;
  localparam int              c_cw  = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_cw-1:0] c_top = c_cw'(c_n - 1);
  localparam logic [WIDTH-1:0] c_msb = WIDTH'(1) << (WIDTH - 1);

  slt_state_e       r_state;
  slt_state_e       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [c_cw-1:0]  r_cnt;
  logic             r_lt;
  logic             r_eq;
  logic             w_slt;
  logic             w_seq;
  logic             w_load;
  logic             w_finish;
  logic             w_res_lt;
  logic             w_res_eq;

  slt_chunk_cmp #(.CHUNK(CHUNK)) u_chunk (
    .i_a  (r_a[WIDTH-1 -: CHUNK]),
    .i_b  (r_b[WIDTH-1 -: CHUNK]),
    .o_lt (w_slt),
    .o_eq (w_seq)
  );

  // Start is only honoured outside RUN so a running compare is never disturbed.
  assign w_load = start && (r_state != RUN);

`ifdef SLT_EARLY_TERM_EN
  assign w_finish = !w_seq || (r_cnt == '0);
  assign w_res_lt = w_slt;
  assign w_res_eq = w_seq;
`else
  logic r_dec;
  logic r_dlt;

  // The first differing slice decides; later slices are scanned but ignored.
  assign w_finish = (r_cnt == '0);
  assign w_res_lt = r_dec ? r_dlt : w_slt;
  assign w_res_eq = !r_dec && w_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec <= 1'b0;
      r_dlt <= 1'b0;
    end else if (w_load) begin
      r_dec <= 1'b0;
      r_dlt <= 1'b0;
    end else if ((r_state == RUN) && !r_dec && !w_seq) begin
      r_dec <= 1'b1;
      r_dlt <= w_slt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_finish) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Flipping the MSB in signed mode maps two's-complement order onto unsigned order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_lt  <= 1'b0;
      r_eq  <= 1'b0;
    end else if (w_load) begin
      r_a   <= a ^ (signed_mode ? c_msb : '0);
      r_b   <= b ^ (signed_mode ? c_msb : '0);
      r_cnt <= c_top;
    end else if (r_state == RUN) begin
      r_a   <= r_a << CHUNK;
      r_b   <= r_b << CHUNK;
      r_cnt <= r_cnt - 1'b1;
      if (w_finish) begin
        r_lt <= w_res_lt;
        r_eq <= w_res_eq;
      end
    end
  end

  assign lt  = r_lt;
  assign eq  = r_eq;
  assign res = WIDTH'(r_lt);

endmodule
`default_nettype wire

// File: tb/tb_slt_seq_cmp.sv
`default_nettype none
// ============================================================
// tb_slt_seq_cmp : scoreboard bench for slt_seq_cmp (WIDTH=32, CHUNK=4)
// Rev 1.0 - initial release
// ============================================================
module tb_slt_seq_cmp;

  localparam int WIDTH = 32;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;
`ifdef SLT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic lt;
    logic eq;
    int   cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sm;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic [WIDTH-1:0] res;

  exp_t q[$];
  exp_t e_mon;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic hold_lt = 1'b0;
  logic hold_eq = 1'b0;

  slt_seq_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (sm),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .lt          (lt),
    .eq          (eq),
    .res         (res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle containing the start edge counts as 1; deciding slice = first differing from MSB.
  function automatic int exp_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int d;
    d = N - 1;
    for (int i = 0; i < WIDTH; i++)
      if (x[i] != y[i]) d = (WIDTH - 1 - i) / CHUNK;
    return EARLY ? d + 2 : N + 1;
  endfunction

  // Called at posedge+2; the following edge accepts the start.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ism);
    exp_t e;
    a     = ia;
    b     = ib;
    sm    = ism;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.lt  = ism ? ($signed(ia) < $signed(ib)) : (ia < ib);
    e.eq  = (ia == ib);
    e.cyc = cyc + exp_latency(ia, ib) - 1;
    q.push_back(e);
    check("busy_after_start", {63'b0, busy}, 64'd1);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: pending=%0d want=0", q.size());
      q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done_cycle();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (done) break;
    end
  endtask

  // Monitor: pops an expectation on every done pulse; otherwise results must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_lt = 1'b0;
      hold_eq = 1'b0;
      check("reset_outputs", {29'b0, busy, done, lt, eq, res}, 64'd0);
    end else if (done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want no pending compare (t=%0t)", $time);
      end else begin
        e_mon = q.pop_front();
        check("lt", {63'b0, lt}, {63'b0, e_mon.lt});
        check("eq", {63'b0, eq}, {63'b0, e_mon.eq});
        check("res", {32'b0, res}, {32'b0, 31'b0, e_mon.lt});
        check("latency_cycle", 64'(cyc), 64'(e_mon.cyc));
        hold_lt = e_mon.lt;
        hold_eq = e_mon.eq;
      end
    end else begin
      check("hold", {30'b0, lt, eq, res}, {30'b0, hold_lt, hold_eq, 31'b0, hold_lt});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    rst_n = 1'b0;
    start = 1'b0;
    sm    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // First edge after reset release must accept the start.
    issue(32'd5, 32'd7, 1'b0);
    drain();
    issue(32'h8000_0000, 32'd1, 1'b0);
    drain();
    issue(32'h8000_0000, 32'd1, 1'b1);
    drain();
    issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    drain();
    issue(32'hFFFF_FFFF, 32'd0, 1'b1);
    drain();

    // Start pulses during RUN must be ignored.
    issue(32'h1234_5678, 32'h1234_5678, 1'b1);
    @(posedge clk);
    #2;
    a     = 32'h0000_0001;
    b     = 32'hF000_0000;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    start = 1'b0;
    drain();

    // Start in the DONE cycle is accepted immediately.
    issue(32'd5, 32'd7, 1'b0);
    wait_done_cycle();
    issue(32'h8000_0000, 32'd1, 1'b1);
    drain();

    // Reset in the third RUN cycle discards the compare.
    issue(32'h0000_0010, 32'h0000_0000, 1'b1);
    drain();
    issue(32'hCAFE_0000, 32'hCAFE_0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_res", {32'b0, res}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    issue(32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    drain();

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = ra ^ 32'h8000_0000;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        wait_done_cycle();
        issue(rb, ra, 1'($urandom_range(0, 1)));
      end
      drain();
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
